// File: rtl/speculoos_pkg.sv
// Shared constants and the event record for the Speculoos shadow-stack event link.
package speculoos_pkg;

    localparam logic [5:0] OPC_JAL  = 6'h01;
    localparam logic [5:0] OPC_JALR = 6'h12;
    localparam logic [5:0] OPC_JR   = 6'h11;

    localparam logic [4:0] LINK_REG = 5'd9;

    localparam logic [1:0] EV_NONE = 2'b00;
    localparam logic [1:0] EV_CALL = 2'b01;
    localparam logic [1:0] EV_RET  = 2'b10;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
    } ev_t;

    localparam int unsigned EV_W = $bits(ev_t);

endpackage

// File: rtl/speculoos_evt_fifo.sv
// Generic synchronous FIFO; a push while full is accepted only if a pop frees the head slot.
module speculoos_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (do_pop && !do_push)
                cnt <= cnt - 1'b1;
        end
    end

    // Storage needs no reset: stale slots are never presented while empty.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rptr];
    assign count = cnt;

endmodule

// File: rtl/speculoos_trace_tx.sv
// Classifies committed call/return instructions and queues them for the shadow-stack monitor.
module speculoos_trace_tx
    import speculoos_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned LINK_OFFSET = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    commit_valid_i,
    input  logic [31:0]             insn_i,
    input  logic [31:0]             address_i,
    input  logic [31:0]             rb_value_i,
    output logic                    ev_valid_o,
    input  logic                    ev_ready_i,
    output logic [1:0]              ev_kind_o,
    output logic [31:0]             ev_addr_o,
    output logic                    cpu_stall_o,
    output logic                    overflow_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    ev_t  new_ev;
    ev_t  head;
    logic push;
    logic fire;
    logic full;
    logic empty;
    logic overflow;
    logic unused_insn;

    assign unused_insn = ^{insn_i[25:16], insn_i[10:0]};

    always_comb begin
        new_ev = '0;
        push   = 1'b0;
        if (commit_valid_i) begin
            case (insn_i[31:26])
                OPC_JAL, OPC_JALR: begin
                    push        = 1'b1;
                    new_ev.kind = EV_CALL;
                    new_ev.addr = address_i + 32'(LINK_OFFSET);
                end
                OPC_JR: begin
                    if (insn_i[15:11] == LINK_REG) begin
                        push        = 1'b1;
                        new_ev.kind = EV_RET;
                        new_ev.addr = rb_value_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fire = ev_valid_o && ev_ready_i;

    speculoos_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (fire),
        .wdata (new_ev),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count_o)
    );

    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (push && full && !fire)
            overflow <= 1'b1;
    end

    assign ev_valid_o  = !empty;
    assign ev_kind_o   = head.kind;
    assign ev_addr_o   = head.addr;
    assign cpu_stall_o = full;
    assign overflow_o  = overflow;

endmodule

// File: tb/tb_speculoos_trace_tx.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops them on each transfer.
module tb_speculoos_trace_tx;

    localparam int          DEPTH = 4;
    localparam logic [31:0] LOFF  = 32'd8;

    logic        clk;
    logic        reset;
    logic        commit_valid_i;
    logic [31:0] insn_i;
    logic [31:0] address_i;
    logic [31:0] rb_value_i;
    logic        ev_valid_o;
    logic        ev_ready_i;
    logic [1:0]  ev_kind_o;
    logic [31:0] ev_addr_o;
    logic        cpu_stall_o;
    logic        overflow_o;
    logic [2:0]  count_o;

    speculoos_trace_tx #(
        .DEPTH       (DEPTH),
        .LINK_OFFSET (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .commit_valid_i (commit_valid_i),
        .insn_i         (insn_i),
        .address_i      (address_i),
        .rb_value_i     (rb_value_i),
        .ev_valid_o     (ev_valid_o),
        .ev_ready_i     (ev_ready_i),
        .ev_kind_o      (ev_kind_o),
        .ev_addr_o      (ev_addr_o),
        .cpu_stall_o    (cpu_stall_o),
        .overflow_o     (overflow_o),
        .count_o        (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [33:0] exp_q[$];
    int          mdl_count;
    bit          mdl_ovf;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference classification straight from the opcode table.
    function automatic bit classify(input logic [31:0] insn, input logic [31:0] pc,
                                    input logic [31:0] rb, output logic [33:0] ev);
        int opc;
        int rbf;
        opc = int'(insn >> 26);
        rbf = int'((insn >> 11) & 32'd31);
        ev  = '0;
        if (opc == 1 || opc == 18) begin
            ev = {2'b01, pc + LOFF};
            return 1'b1;
        end
        if (opc == 17 && rbf == 9) begin
            ev = {2'b10, rb};
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Monitor: every transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && ev_valid_o === 1'b1 && ev_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, ev_kind_o}, 32'd0);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("ev_kind", {30'd0, ev_kind_o}, {30'd0, e[33:32]});
                chk("ev_addr", ev_addr_o, e[31:0]);
            end
        end
    end

    task automatic step(input bit c, input logic [31:0] insn, input logic [31:0] pc,
                        input logic [31:0] rb, input bit rdy, input bit rst);
        logic [33:0] ev;
        bit          is_ev;
        bit          pop;
        commit_valid_i = c;
        insn_i         = insn;
        address_i      = pc;
        rb_value_i     = rb;
        ev_ready_i     = rdy;
        reset          = rst;
        if (rst) begin
            mdl_count = 0;
            mdl_ovf   = 1'b0;
            exp_q.delete();
        end else begin
            pop   = (mdl_count != 0) && rdy;
            is_ev = c && classify(insn, pc, rb, ev);
            if (is_ev) begin
                if (mdl_count == DEPTH && !pop) begin
                    mdl_ovf = 1'b1;
                end else begin
                    exp_q.push_back(ev);
                    mdl_count++;
                end
            end
            if (pop) mdl_count--;
        end
        @(posedge clk);
        #1;
        chk("count", {29'd0, count_o}, mdl_count);
        chk("valid", {31'd0, ev_valid_o}, {31'd0, mdl_count != 0});
        chk("stall", {31'd0, cpu_stall_o}, {31'd0, mdl_count == DEPTH});
        chk("overflow", {31'd0, overflow_o}, {31'd0, mdl_ovf});
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && mdl_count != 0; i++) idle(1'b1);
        chk("drain_done", mdl_count, 0);
        idle(1'b0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic jal_at(input logic [31:0] pc, input bit rdy);
        step(1'b1, 32'h04000000 | ($urandom & 32'h03FFFFFF), pc, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mdl_count = 0;
        mdl_ovf = 1'b0;

        // Reset: two cycles, then quiet
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("reset_kind", {30'd0, ev_kind_o}, 32'd0);
        chk("reset_addr", ev_addr_o, 32'd0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Call then return
        step(1'b1, 32'h04000010, 32'h00001000, 32'h0, 1'b0, 1'b0);
        chk("call_kind", {30'd0, ev_kind_o}, 32'd1);
        chk("call_addr", ev_addr_o, 32'h00001008);
        step(1'b1, 32'h44004800, 32'h00001234, 32'h00001008, 1'b0, 1'b0);
        drain();

        // Non-events
        step(1'b1, 32'h44001800, 32'h00002000, 32'h00005555, 1'b1, 1'b0);
        step(1'b1, 32'h9C210004, 32'h00002004, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h04000010, 32'h00002008, 32'h0, 1'b1, 1'b0);
        idle(1'b1);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) jal_at(32'h00003000 + 32'(16 * i), 1'b0);
        jal_at(32'h0000F000, 1'b0);
        idle(1'b0);
        drain();

        // Full with simultaneous push and pop
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) jal_at(32'h00004000 + 32'(16 * i), 1'b0);
        step(1'b1, 32'h48000000 | ($urandom & 32'h03FFFFFF), 32'h00005000, 32'h0, 1'b1, 1'b0);
        drain();

        // Reset mid-drain
        for (int i = 0; i < 3; i++) jal_at(32'h00006000 + 32'(16 * i), 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Random traffic with wraparound addresses and occasional resets
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r;
            logic [31:0] insn;
            logic [31:0] pc;
            logic [4:0]  rbf;
            bit          rdy;
            r = $urandom;
            case ($urandom_range(0, 5))
                0: insn = {6'h01, r[25:0]};
                1: insn = {6'h12, r[25:0]};
                2: insn = {6'h11, r[25:16], 5'd9, r[10:0]};
                3: begin
                    rbf  = 5'($urandom_range(0, 31));
                    if (rbf == 5'd9) rbf = 5'd3;
                    insn = {6'h11, r[25:16], rbf, r[10:0]};
                end
                4: insn = {6'h27, r[25:0]};
                default: insn = $urandom;
            endcase
            pc  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | (r & 32'hC)) : $urandom;
            rdy = (n % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 2) != 0, insn, pc, $urandom, rdy,
                 $urandom_range(0, 299) == 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
